tx_arbiter: RTL and testbench
=============================

Name: tx_arbiter

Overview:
- Round-robin scheduler that shares the single serial transmit path (TX controller, shift register and bit counter) among NREQ requesters.
- Captures the winning requester's byte and issues a one-cycle start pulse plus data to the TX controller.
- Waits for the controller's done and applies a watchdog, so a lost done cannot hang the link.
- Sits between client blocks and the TX controller's pulse/done interface.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DATA_W, 8, width of each transmit word.
- TIMEOUT, 1024, maximum WAIT cycles before abort; 0 disables the watchdog.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- req  input  NREQ  per-requester transmit request; level, held until gnt.
- req_data  input  NREQ*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  output  NREQ  one-hot, one-cycle; the word of that requester has been captured.
- tx_pulse  output  1  one-cycle start strobe to the TX controller.
- tx_data  output  DATA_W  captured word, stable from tx_pulse until the next capture.
- tx_done  input  1  completion from the TX bit counter.
- busy  output  1  high whenever state is not IDLE.
- owner  output  clog2(NREQ)  index of the current or last granted requester.
- err  output  1  one-cycle pulse on watchdog abort.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: all outputs and internal registers 0 (gnt, tx_pulse, tx_data, owner, err, busy, rr_ptr, timeout counter); state = IDLE.
- rst overrides everything, including mid-WAIT. After reset no gnt or tx_pulse is issued until a fresh arbitration in IDLE.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, GAP.
- IDLE, no req: stay in IDLE.
- IDLE, req != 0, in cycle N:
  - winner = first set bit scanning circularly from rr_ptr upward (rr_ptr, rr_ptr+1, ..., wrap to 0).
  - At the edge ending cycle N: owner <= winner; tx_data <= req_data slice of winner; gnt[winner] <= 1; tx_pulse <= 1; state <= ISSUE.
- ISSUE (cycle N+1):
  - gnt and tx_pulse are high for exactly this cycle.
  - state <= WAIT; timeout counter <= 0.
  - No arbitration. tx_done is ignored.
- WAIT (from cycle N+2):
  - tx_done = 1: state <= GAP; rr_ptr <= (owner+1) mod NREQ, wrapping NREQ-1 to 0.
  - Else, if TIMEOUT != 0 and counter == TIMEOUT-1: err <= 1 for one cycle; rr_ptr advances the same way; state <= GAP.
  - Else: counter increments.
  - tx_done and the timeout condition in the same cycle: done wins, no err.
- GAP: one idle cycle, then state <= IDLE. This guarantees at least a 1-cycle gap between the controller's done and the next tx_pulse.
- tx_done outside WAIT: ignored.
- Minimum turnaround: tx_done sampled in cycle D gives GAP at D+1, arbitration at D+2, tx_pulse at D+3.
- Requester protocol:
  - Hold req and req_data until gnt is seen. Deassert req the cycle after gnt unless another word is ready.
  - A req still high in the next IDLE is arbitrated again under normal round-robin rules.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 transfers.
- Changes to req during ISSUE, WAIT or GAP have no effect until IDLE.
- Counter width: clog2(TIMEOUT+1) bits, with a minimum of 1. It must not wrap before TIMEOUT-1.

Test Plan:
- Single requester: rst, then req=4'b0001 with req_data[7:0]=8'hA5 at cycle N -> gnt=0001 and tx_pulse=1 at N+1 only, tx_data=A5, owner=0, busy=1; tx_done at N+6 -> busy=0 at N+8, next grant no earlier than N+9.
- Simultaneous requests: req=4'b1010 held, data1=11, data3=33, tx_done returned 5 cycles after each pulse -> grant order 1,3,1,3; tx_data sequence 11,33,11,33; every gnt one-hot.
- Wrap-around fairness: req=4'b1111 held for 8 transfers -> owner sequence 0,1,2,3,0,1,2,3; rr_ptr wraps from 3 to 0.
- Watchdog with TIMEOUT=8: tx_done never asserted -> err high for one cycle exactly 8 WAIT cycles after ISSUE, then GAP and IDLE; next arbitration starts after the aborted owner. With tx_done in the same cycle as the timeout -> no err.
- Reset mid-WAIT: rst for one cycle in WAIT -> next cycle all outputs 0, state IDLE, rr_ptr=0; a tx_done arriving afterwards is ignored.
- Spurious done: tx_done pulsed in IDLE and ISSUE -> no state change; WAIT still requires a fresh tx_done.

Source files
------------

// File: rtl/tx_arbiter_if.sv
// Handshake bundle between transmit clients, the round-robin TX arbiter and the TX controller.
// The arbiter connects through the slave modport; clients and the controller use master.
interface tx_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 8
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        gnt;
    logic                   tx_pulse;
    logic [DATA_W-1:0]      tx_data;
    logic                   tx_done;
    logic                   busy;
    logic [IDX_W-1:0]       owner;
    logic                   err;

    modport master (
        output req, req_data, tx_done,
        input  gnt, tx_pulse, tx_data, busy, owner, err
    );

    modport slave (
        input  req, req_data, tx_done,
        output gnt, tx_pulse, tx_data, busy, owner, err
    );
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one serial TX controller among NREQ requesters,
// with a one-cycle start strobe, a done wait guarded by a watchdog, and a post-done gap.
module tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk_i,
    input  logic         rst_i,
    tx_arbiter_if.slave  bus
);
    localparam int IDX_W   = $clog2(NREQ);
    localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit WDOG_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = WDOG_EN ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    state_e            state_q;
    logic [NREQ-1:0]   gnt_q;
    logic              tx_pulse_q;
    logic [DATA_W-1:0] tx_data_q;
    logic [IDX_W-1:0]  owner_q;
    logic              err_q;
    logic              busy_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              win_vld_d;
    logic [IDX_W-1:0]  win_idx_d;
    logic [DATA_W-1:0] win_data_d;
    logic [IDX_W-1:0]  rr_next_d;
    logic [CNT_W-1:0]  cnt_inc_d;

    // (base + ofs) mod NREQ without a divider; ofs never exceeds NREQ-1
    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int ofs);
        logic [IDX_W:0] sum;
        sum = {1'b0, base} + (IDX_W+1)'(ofs);
        if (sum >= (IDX_W+1)'(NREQ)) begin
            sum = sum - (IDX_W+1)'(NREQ);
        end else begin
            sum = sum;
        end
        return sum[IDX_W-1:0];
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NREQ-1:0] vec;
        vec      = {NREQ{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Circular priority scan starting at rr_ptr_q: the first asserted request wins
    always_comb begin
        win_vld_d = 1'b0;
        win_idx_d = {IDX_W{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            if (!win_vld_d && bus.req[rr_index(rr_ptr_q, k)]) begin
                win_vld_d = 1'b1;
                win_idx_d = rr_index(rr_ptr_q, k);
            end else begin
                win_vld_d = win_vld_d;
                win_idx_d = win_idx_d;
            end
        end
    end

    // Winner's data word, next round-robin start point and watchdog increment
    always_comb begin
        win_data_d = bus.req_data[int'(win_idx_d) * DATA_W +: DATA_W];
        cnt_inc_d  = cnt_q + CNT_W'(1);
        if (owner_q == IDX_LAST) begin
            rr_next_d = {IDX_W{1'b0}};
        end else begin
            rr_next_d = owner_q + IDX_W'(1);
        end
    end

    // Scheduler FSM; gnt, tx_pulse and err default low so they only ever last one cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            gnt_q      <= {NREQ{1'b0}};
            tx_pulse_q <= 1'b0;
            tx_data_q  <= {DATA_W{1'b0}};
            owner_q    <= {IDX_W{1'b0}};
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            rr_ptr_q   <= {IDX_W{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            gnt_q      <= {NREQ{1'b0}};
            tx_pulse_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (win_vld_d) begin
                        owner_q    <= win_idx_d;
                        tx_data_q  <= win_data_d;
                        gnt_q      <= onehot(win_idx_d);
                        tx_pulse_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end else begin
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= {CNT_W{1'b0}};
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // done takes priority over a watchdog expiry in the same cycle
                    if (bus.tx_done) begin
                        rr_ptr_q <= rr_next_d;
                        state_q  <= ST_GAP;
                    end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
                        err_q    <= 1'b1;
                        rr_ptr_q <= rr_next_d;
                        state_q  <= ST_GAP;
                    end else begin
                        cnt_q    <= cnt_inc_d;
                        state_q  <= ST_WAIT;
                    end
                end
                ST_GAP: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.tx_pulse = tx_pulse_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.owner    = owner_q;
    assign bus.err      = err_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: a table of round-robin transfers plus hand-timed sequences for
// turnaround, watchdog, reset and spurious-done corners; grants scored through a queue.
module tb_tx_arbiter;
    localparam int NREQ    = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tx_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus ();

    tx_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] owner;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        logic [1:0] owner;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_xfer(input logic [1:0] owner, input logic [7:0] data);
        exp_t e;
        e.owner = owner;
        e.data  = data;
        sb_q.push_back(e);
    endtask

    // Returns in the cycle where tx_pulse is seen (ISSUE), bounded by a cycle budget
    task automatic wait_pulse(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.tx_pulse === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL pulse_timeout: got no tx_pulse expected one within 20 cycles");
    endtask

    // Called in the ISSUE cycle: done arrives dly cycles later, returns in the following IDLE cycle
    task automatic finish_xfer(input int dly);
        repeat (dly) step();
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.req     = 4'b0000;
        bus.tx_done = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Scoreboard: every tx_pulse must match the oldest expected transfer
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.tx_pulse === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got owner %0d expected no pulse", bus.owner);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_gnt", 32'(bus.gnt), 32'(1) << e.owner);
                    check("sb_owner", 32'(bus.owner), 32'(e.owner));
                    check("sb_data", 32'(bus.tx_data), 32'(e.data));
                end
            end else if (bus.gnt !== 4'b0000) begin
                check("gnt_without_pulse", 32'(bus.gnt), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected one before 200000");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t vecs[17];
        bit   ok;

        vecs = '{
            '{4'b1010, 2'd1}, '{4'b1010, 2'd3}, '{4'b1010, 2'd1}, '{4'b1010, 2'd3},
            '{4'b1111, 2'd0}, '{4'b1111, 2'd1}, '{4'b1111, 2'd2}, '{4'b1111, 2'd3},
            '{4'b1111, 2'd0}, '{4'b1111, 2'd1}, '{4'b1111, 2'd2}, '{4'b1111, 2'd3},
            '{4'b0100, 2'd2}, '{4'b0011, 2'd0}, '{4'b1001, 2'd3}, '{4'b1000, 2'd3},
            '{4'b0110, 2'd1}
        };

        bus.req      = 4'b0000;
        bus.req_data = 32'h0000_0000;
        bus.tx_done  = 1'b0;

        // Reset values
        do_reset();
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_pulse", 32'(bus.tx_pulse), 32'd0);
        check("rst_data", 32'(bus.tx_data), 32'd0);
        check("rst_owner", 32'(bus.owner), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);

        // Single requester with exact turnaround timing (cycle N = now)
        bus.req_data = 32'h0000_00A5;
        bus.req      = 4'b0001;
        expect_xfer(2'd0, 8'hA5);
        step();                                      // N+1
        check("single_gnt", 32'(bus.gnt), 32'h1);
        check("single_pulse", 32'(bus.tx_pulse), 32'd1);
        check("single_data", 32'(bus.tx_data), 32'hA5);
        check("single_busy", 32'(bus.busy), 32'd1);
        bus.req = 4'b0000;
        step();                                      // N+2
        check("single_pulse_once", 32'(bus.tx_pulse), 32'd0);
        check("single_busy_wait", 32'(bus.busy), 32'd1);
        repeat (4) step();                           // N+6
        bus.tx_done = 1'b1;
        step();                                      // N+7 (GAP)
        bus.tx_done  = 1'b0;
        check("single_busy_gap", 32'(bus.busy), 32'd1);
        bus.req_data = 32'h0000_005A;
        bus.req      = 4'b0001;
        expect_xfer(2'd0, 8'h5A);
        step();                                      // N+8
        check("single_busy_idle", 32'(bus.busy), 32'd0);
        check("single_no_early_pulse", 32'(bus.tx_pulse), 32'd0);
        step();                                      // N+9
        check("single_regrant_pulse", 32'(bus.tx_pulse), 32'd1);
        check("single_regrant_data", 32'(bus.tx_data), 32'h5A);
        bus.req = 4'b0000;
        finish_xfer(5);

        // Table: alternating pair, full wrap-around, assorted patterns
        do_reset();
        bus.req_data = 32'h3322_1100;
        foreach (vecs[i]) begin
            bus.req = vecs[i].req;
            expect_xfer(vecs[i].owner, 8'(vecs[i].owner * 8'h11));
            wait_pulse(ok);
            if (ok) begin
                finish_xfer(5);
            end else begin
                do_reset();
            end
        end
        bus.req = 4'b0000;
        step();

        // Watchdog abort, then arbitration resumes after the aborted owner
        do_reset();
        bus.req = 4'b0100;
        expect_xfer(2'd2, 8'h22);
        wait_pulse(ok);                              // P (ISSUE)
        bus.req = 4'b0000;
        for (int i = 1; i <= TIMEOUT; i++) begin
            step();
            check("wdog_err_early", 32'(bus.err), 32'd0);
        end
        step();                                      // P+9 (GAP)
        check("wdog_err", 32'(bus.err), 32'd1);
        check("wdog_busy_gap", 32'(bus.busy), 32'd1);
        bus.req = 4'b0101;
        expect_xfer(2'd0, 8'h00);
        step();                                      // P+10 (IDLE)
        check("wdog_err_once", 32'(bus.err), 32'd0);
        check("wdog_busy_idle", 32'(bus.busy), 32'd0);
        wait_pulse(ok);                              // Q (ISSUE)
        bus.req = 4'b0000;

        // Done coinciding with the last watchdog cycle: no err
        repeat (TIMEOUT) step();                     // Q+8
        bus.tx_done = 1'b1;
        step();                                      // Q+9 (GAP)
        bus.tx_done = 1'b0;
        check("done_wins_err", 32'(bus.err), 32'd0);
        check("done_wins_busy", 32'(bus.busy), 32'd1);
        step();
        check("done_wins_idle", 32'(bus.busy), 32'd0);

        // Reset in the middle of WAIT
        bus.req = 4'b0010;
        expect_xfer(2'd1, 8'h11);
        wait_pulse(ok);
        bus.req = 4'b0000;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_gnt", 32'(bus.gnt), 32'd0);
        check("midrst_pulse", 32'(bus.tx_pulse), 32'd0);
        check("midrst_data", 32'(bus.tx_data), 32'd0);
        check("midrst_owner", 32'(bus.owner), 32'd0);
        check("midrst_err", 32'(bus.err), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        bus.tx_done = 1'b1;                          // late done, also spurious in IDLE
        step();
        bus.tx_done = 1'b0;
        check("late_done_busy", 32'(bus.busy), 32'd0);
        step();
        check("late_done_idle", 32'(bus.busy), 32'd0);

        // Spurious done in IDLE and ISSUE; rr_ptr restarted at 0 so 1001 picks requester 0
        bus.req     = 4'b1001;
        bus.tx_done = 1'b1;
        expect_xfer(2'd0, 8'h00);
        step();                                      // ISSUE, done still high
        check("spur_pulse", 32'(bus.tx_pulse), 32'd1);
        check("spur_owner", 32'(bus.owner), 32'd0);
        bus.req = 4'b0000;
        step();                                      // first WAIT cycle
        bus.tx_done = 1'b0;
        check("spur_busy_wait", 32'(bus.busy), 32'd1);
        step();
        step();
        check("spur_still_wait", 32'(bus.busy), 32'd1);
        check("spur_no_err", 32'(bus.err), 32'd0);
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        check("spur_gap_busy", 32'(bus.busy), 32'd1);
        step();
        check("spur_idle_busy", 32'(bus.busy), 32'd0);

        step();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
